// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data memory with valid/ready request and response
// channels, byte-masked stores and a programmable response latency.
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake (accepted only in IDLE)
//   req_we_i                  1 = store, 0 = load
//   req_addr_i                byte address
//   req_be_i, req_wdata_i     store byte enables and lane-aligned data
//   resp_valid_o/resp_ready_i response handshake
//   resp_rdata_o              aligned load word, 0 for stores and faults
//   resp_error_o              out-of-range address or illegal byte enables
module dmem_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_error_o
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          a_we;
  logic [31:0]   a_addr, a_wdata;
  logic [3:0]    a_be;
  logic          c_we;
  logic [31:0]   c_addr, c_wdata, off;
  logic [3:0]    c_be;
  logic [AW-1:0] idx;
  logic          oor, be_ok, fault, enter;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [MEM_WORDS];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else state <= nxt;
  end

  // The counter holds the WAIT cycles still to come, so RESP follows the
  // cycle in which it would reach zero; LATENCY==1 skips WAIT entirely.
  always_comb begin
    nxt = state == S_IDLE ? (req_valid_i ? (LATENCY == 1 ? S_RESP : S_WAIT) : S_IDLE) :
          state == S_WAIT ? (cnt == CW'(1) ? S_RESP : S_WAIT) :
          (resp_ready_i ? S_IDLE : S_RESP);
  end

  always_comb begin
    req_ready_o  = rstn_i && state == S_IDLE;
    resp_valid_o = state == S_RESP;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_we    <= 1'b0;
      a_addr  <= '0;
      a_be    <= '0;
      a_wdata <= '0;
      cnt     <= '0;
    end else if (state == S_IDLE && req_valid_i) begin
      a_we    <= req_we_i;
      a_addr  <= req_addr_i;
      a_be    <= req_be_i;
      a_wdata <= req_wdata_i;
      cnt     <= CW'(LATENCY - 1);
    end else if (state == S_WAIT) begin
      cnt <= cnt - 1'b1;
    end
  end

  // With LATENCY==1 the array is accessed straight from the request inputs,
  // since the capture registers load on the same edge.
  always_comb begin
    c_we    = state == S_IDLE ? req_we_i : a_we;
    c_addr  = state == S_IDLE ? req_addr_i : a_addr;
    c_be    = state == S_IDLE ? req_be_i : a_be;
    c_wdata = state == S_IDLE ? req_wdata_i : a_wdata;
    off     = c_addr - BASE_ADDR;
    idx     = off[AW+1:2];
    oor     = c_addr < BASE_ADDR || |off[31:AW+2];
    be_ok   = c_be == 4'b0001 << off[1:0] ||
              (c_be == 4'b0011 && off[1:0] == 2'd0) ||
              (c_be == 4'b1100 && off[1:0] == 2'd2) ||
              (c_be == 4'b1111 && off[1:0] == 2'd0);
    fault   = oor || (c_we && !be_ok);
    enter   = rstn_i && state != S_RESP && nxt == S_RESP;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter) begin
      rdata_q <= (c_we || fault) ? '0 : mem[idx];
      err_q   <= fault;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enter && c_we && !fault)
      for (int i = 0; i < 4; i++)
        if (c_be[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
  end

  assign resp_rdata_o = rdata_q;
  assign resp_error_o = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder
// (LATENCY=2 instance) plus a LATENCY=1 instance for the throughput test.
module tb_dmem_responder;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          WORDS = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_error;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_be;
  logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_error1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;
  logic [3:0]  req_be1;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [int];
  logic [31:0] msk [int];

  dmem_responder #(.MEM_WORDS(WORDS), .LATENCY(2), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_error_o(resp_error)
  );

  dmem_responder #(.MEM_WORDS(WORDS), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
    .req_addr_i(req_addr1), .req_be_i(req_be1), .req_wdata_i(req_wdata1),
    .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1),
    .resp_rdata_o(resp_rdata1), .resp_error_o(resp_error1)
  );

  function automatic logic exp_err(input logic we, input logic [31:0] a, input logic [3:0] be);
    logic [31:0] off;
    int lane;
    off = a - BASE;
    if (a < BASE || off >= 32'(4 * WORDS)) return 1'b1;
    if (!we) return 1'b0;
    lane = int'(a % 4);
    if (be == 4'd1 || be == 4'd2 || be == 4'd4 || be == 4'd8) return int'(be) != (1 << lane);
    if (be == 4'd3 || be == 4'd15) return lane != 0;
    if (be == 4'd12) return lane != 2;
    return 1'b1;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    rd = 'x;
    er = 1'bx;
    lat = -1;
    @(negedge clk);
    req_we = we; req_addr = a; req_be = be; req_wdata = wd; req_valid = 1'b1; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
      return;
    end
    lat = n; rd = resp_rdata; er = resp_error; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_be = 0; req_wdata = 0; resp_ready = 0;
    req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_be1 = 0; req_wdata1 = 0; resp_ready1 = 1;
    repeat (3) @(negedge clk);
    checks++; if ({req_ready, req_ready1} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", {req_ready, req_ready1}); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", resp_rdata); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", resp_error); end
    rstn = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_word_roundtrip;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL word_store: got err=%b rdata=%h required 0/0", er, rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL store_latency: got %0d required 2", lat); end
    do_req(1'b0, 32'h100, 4'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load: got err=%b rdata=%h required 0/deadbeef", er, rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL load_latency: got %0d required 2", lat); end
  endtask

  task automatic test_byte_merge;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h200, 4'hF, 32'h11223344, rd, er, lat);
    do_req(1'b1, 32'h202, 4'b0100, 32'h00AA0000, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL byte_store: got err=%b required 0", er); end
    do_req(1'b0, 32'h200, 4'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h11AA3344) begin errors++; $display("FAIL byte_merge: got err=%b rdata=%h required 0/11aa3344", er, rd); end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    req_we = 0; req_addr = 32'h100; req_be = 0; req_valid = 1'b1; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_addr = 32'h200;
    n = 0;
    while (!resp_valid && n < 20) begin
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_wait_ready: got %b required 0", req_ready); end
      @(negedge clk); n++;
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: got valid=%b rdata=%h ready=%b required 1/deadbeef/0", resp_valid, resp_rdata, req_ready);
      end
      if (i == 5) resp_ready = 1'b1;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got ready=%b valid=%b required 1/0", req_ready, resp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_taken: got %b required 0", req_ready); end
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11AA3344) begin errors++; $display("FAIL bp_second_data: got valid=%b rdata=%h required 1/11aa3344", resp_valid, resp_rdata); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_faults;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h4000, 4'hF, 32'hCAFEF00D, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL fault_oor_store: got err=%b rdata=%h required 1/0", er, rd); end
    do_req(1'b1, 32'h201, 4'b0011, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL fault_misaligned_half: got err=%b rdata=%h required 1/0", er, rd); end
    do_req(1'b0, 32'h4000, 4'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL fault_oor_load: got err=%b rdata=%h required 1/0", er, rd); end
    do_req(1'b1, 32'h200, 4'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL fault_zero_be: got err=%b required 1", er); end
    do_req(1'b0, 32'h200, 4'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h11AA3344) begin errors++; $display("FAIL fault_no_write: got err=%b rdata=%h required 0/11aa3344", er, rd); end
    do_req(1'b0, 32'h203, 4'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h11AA3344) begin errors++; $display("FAIL unaligned_load: got err=%b rdata=%h required 0/11aa3344", er, rd); end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] rd; logic er; int lat, n, seen;
    do_req(1'b1, 32'h300, 4'hF, 32'h12345678, rd, er, lat);
    @(negedge clk);
    req_we = 1; req_addr = 32'h300; req_be = 4'hF; req_wdata = 32'h55555555; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_accepted: got ready=%b required 0", req_ready); end
    rstn = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL abort_in_reset: got valid=%b ready=%b required 0/0", resp_valid, req_ready); end
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (resp_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_resp: got %0d responses required 0", seen); end
    do_req(1'b0, 32'h300, 4'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h12345678) begin errors++; $display("FAIL abort_no_write: got err=%b rdata=%h required 0/12345678", er, rd); end
  endtask

  task automatic test_lat1;
    logic [31:0] d [4];
    int r;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    @(negedge clk);
    req_we1 = 1'b1; req_addr1 = 32'h40; req_be1 = 4'hF; req_wdata1 = d[0]; req_valid1 = 1'b1;
    for (int j = 0; j < 16; j++) begin
      r = j / 2;
      if (j % 2 == 0) begin
        checks++; if ({req_ready1, resp_valid1} !== 2'b10) begin errors++; $display("FAIL lat1_accept_slot%0d: got ready/valid=%b required 10", j, {req_ready1, resp_valid1}); end
      end else begin
        checks++; if ({req_ready1, resp_valid1, resp_error1} !== 3'b010 || resp_rdata1 !== (r < 4 ? 32'h0 : d[r-4])) begin
          errors++; $display("FAIL lat1_resp_slot%0d: got ready/valid/err=%b rdata=%h required 010 rdata=%h", j, {req_ready1, resp_valid1, resp_error1}, resp_rdata1, r < 4 ? 32'h0 : d[r-4]);
        end
        if (r < 7) begin
          req_we1 = r + 1 < 4; req_addr1 = 32'h40 + 32'(4 * ((r + 1) % 4)); req_wdata1 = d[(r + 1) % 4];
        end else req_valid1 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [3:0] legal [7];
    logic we, er, e;
    logic [31:0] a, wd, rd, m;
    logic [3:0] be;
    int lat, sel, w;
    legal = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 7));
      a = sel == 0 ? 32'h4000 + $urandom_range(0, 255) : sel == 1 ? 32'hFFFFFFFC : $urandom_range(0, 255);
      be = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 6)];
      wd = $urandom;
      do_req(we, a, be, wd, rd, er, lat);
      e = exp_err(we, a, be);
      w = int'((a - BASE) / 4);
      m = (!we && !e && msk.exists(w)) ? msk[w] : 32'h0;
      checks++; if (er !== e || lat != 2 || ((we || e) ? rd !== 32'h0 : (rd & m) !== (mdl[w] & m))) begin
        errors++; $display("FAIL random_%0d: we=%b addr=%h be=%b got err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=2", k, we, a, be, er, rd, lat, e, (we || e) ? 32'h0 : mdl[w] & m);
      end
      if (we && !e) begin
        if (!mdl.exists(w)) begin mdl[w] = 32'h0; msk[w] = 32'h0; end
        for (int i = 0; i < 4; i++) if (be[i]) begin mdl[w][8*i +: 8] = wd[8*i +: 8]; msk[w][8*i +: 8] = 8'hFF; end
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_roundtrip;
    test_byte_merge;
    test_backpressure;
    test_faults;
    test_lat1;
    test_reset_midflight;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the core's memory stage, at the far end of the load/store request interface. It accepts one request at a time over a valid/ready handshake and performs a word-wide read or byte-masked write to an internal word array. After a programmable latency it returns read data or an error over a valid/ready response channel. It is the simulation/FPGA backing store the memory stage and store-buffer drain talk to.

Parameters:
MEM_WORDS, 4096, number of 32-bit words in the array (power of two)
LATENCY, 2, cycles from request acceptance to resp_valid_o assertion (must be >= 1)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0 (word aligned)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  responder can accept a request this cycle
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address
req_be_i  in  4  byte enables, stores only; loads always return the full word
req_wdata_i  in  32  store data, byte lanes already aligned to the address
resp_valid_o  out  1  response present
resp_ready_i  in  1  requester accepts the response
resp_rdata_o  out  32  load data: full aligned word, 0 for stores and errors
resp_error_o  out  1  access fault, meaning out of range or illegal byte-enable

Behaviour:
- Reset values: req_ready_o=0 while rstn_i is low, and 1 in the first cycle after release. resp_valid_o=0, resp_rdata_o=0, resp_error_o=0. FSM goes to IDLE and the latency counter to 0. Array contents are not cleared by reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready_o=1.
  - When req_valid_i is high, capture we, addr, be and wdata, load counter = LATENCY-1, then go to WAIT.
  - If LATENCY==1, go directly to RESP.
- WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle; at 0, go to RESP.
- RESP:
  - resp_valid_o=1, and resp_rdata_o/resp_error_o stay stable until the handshake.
  - On resp_ready_i, go to IDLE.
  - No back-to-back overlap: a new request is accepted only in IDLE. Minimum occupancy is LATENCY+1 cycles per request (handshake cycle included).
- Array access timing: the array is accessed at the cycle of entering RESP, never at acceptance.
  - Store: write only the bytes where be=1.
  - Load: latch the word at addr[log2(MEM_WORDS)+1:2] offset from BASE_ADDR.
- Error conditions (resp_error_o=1, no array write, rdata=0):
  - (addr - BASE_ADDR) >= 4*MEM_WORDS, or addr < BASE_ADDR.
  - Store with be == 4'b0000.
  - Store whose be is not one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111.
  - Store with be not consistent with addr[1:0]: a byte store must have be = 1<<addr[1:0]; a half store needs addr[0]=0; a word store needs addr[1:0]=0.
  - Load with addr[1:0] != 0 is NOT an error. It returns the aligned word, and the requester extracts the lanes.
- resp_ready_i high outside RESP is ignored. req_valid_i high outside IDLE is held off by req_ready_o=0; the requester must keep the request stable until it is accepted.
- Reset mid-operation: an in-flight request is discarded. A pending store that has not reached RESP is not written. No response is produced after reset.
- Address arithmetic is unsigned 32-bit, and the subtraction wraps. Any index bits above log2(MEM_WORDS) make the access out of range.

Test Plan:
- Word round-trip:
  - Stimulus: store addr 0x100, be 1111, wdata 0xDEADBEEF, then load 0x100 (LATENCY=2).
  - Required: store response error=0 arrives 2 cycles after acceptance; load returns 0xDEADBEEF with error=0.
- Byte merge:
  - Stimulus: store 0x11223344 to 0x200, then byte store to 0x202 with be 0100, wdata 0x00AA0000, then load 0x200.
  - Required: load returns 0x11AA3344.
- Backpressure:
  - Stimulus: load while resp_ready_i is held low for 5 cycles, with a second req_valid_i asserted throughout.
  - Required: resp_valid_o and resp_rdata_o are stable for all 5 cycles, req_ready_o=0 throughout, and the second request is accepted the cycle after the response handshake.
- Faults:
  - Stimulus: store to 4*MEM_WORDS (0x4000); then store to 0x201 with be 0011; then load 0x4000.
  - Required: all three respond with error=1 and rdata=0; a later load of 0x200 is unchanged.
- Reset mid-flight:
  - Stimulus: accept store 0x300 = 0x55555555, assert rstn_i low during WAIT, release, then load 0x300.
  - Required: no response for the aborted store, and the load returns the pre-existing contents.
- LATENCY=1 build:
  - Stimulus: back-to-back loads with resp_ready_i tied high.
  - Required: a response the cycle after each acceptance and a throughput of one request every 2 cycles.
